// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline skid stage.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 4;
    localparam int ALUC_W = 3;

    // RegWrite, MemtoReg, MemWrite, Branch, ALUSrc sit at the top of the bundle.
    localparam int CTRL_W = 5;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with async clear and a synchronous
// clear of the control field (top CTRL_W bits) used for squashing.
module pipe_payload_reg #(
    parameter int W      = 8,
    parameter int CTRL_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr_ctrl,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Squash wins over load; data bits survive a squash.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr_ctrl) begin
            r_q[W-1 -: CTRL_W] <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID->EX pipeline register built as a 2-entry skid buffer.
// The main entry drives the EX outputs; the skid entry catches a payload
// accepted while EX stalls, so in_ready never depends on out_ready.
//
//   state | meaning
//   EMPTY | nothing held, outputs show a bubble
//   ONE   | main valid, skid free
//   FULL  | main and skid valid, upstream stalled
module pipe_id_ex_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RA_W   = pipe_pkg::RA_W,
    parameter int ALUC_W = pipe_pkg::ALUC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [RA_W-1:0]   WA3D,
    input  logic [DATA_W-1:0] rd1D,
    input  logic [DATA_W-1:0] rd2D,
    input  logic [DATA_W-1:0] ExtImmD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [RA_W-1:0]   WA3E,
    output logic [DATA_W-1:0] rd1E,
    output logic [DATA_W-1:0] rd2E,
    output logic [DATA_W-1:0] ExtImmE,
    output logic [1:0]        occ
);

    localparam int PW = CTRL_W + ALUC_W + RA_W + 3*DATA_W;

    pipe_state_e r_state;
    pipe_state_e w_state_nx;
    logic        r_in_ready;
    logic        r_out_valid;

    logic          w_accept;
    logic          w_consume;
    logic          w_main_en;
    logic          w_skid_en;
    logic [PW-1:0] w_in_bus;
    logic [PW-1:0] w_main_d;
    logic [PW-1:0] w_main_q;
    logic [PW-1:0] w_skid_q;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = r_out_valid & out_ready;

    assign w_in_bus = {RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
                       ALUControlD, WA3D, rd1D, rd2D, ExtImmD};

    // Next state; flush dominates every other event.
    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) w_state_nx = ONE;
                ONE:     if (w_accept && !w_consume) w_state_nx = FULL;
                         else if (!w_accept && w_consume) w_state_nx = EMPTY;
                FULL:    if (w_consume) w_state_nx = ONE;
                default: w_state_nx = EMPTY;
            endcase
        end
    end

    // Main loads from input, except when draining the skid entry into it.
    always_comb begin
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        if (!flush) begin
            w_main_en = ((r_state == EMPTY) && w_accept) ||
                        ((r_state == ONE)   && w_accept && w_consume) ||
                        ((r_state == FULL)  && w_consume);
            w_skid_en = (r_state == ONE) && w_accept && !w_consume;
        end
        w_main_d = (r_state == FULL) ? w_skid_q : w_in_bus;
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx != FULL);
            r_out_valid <= (w_state_nx != EMPTY);
        end
    end

    pipe_payload_reg #(.W(PW), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_main_en),
        .i_clr_ctrl (flush),
        .i_d        (w_main_d),
        .o_q        (w_main_q)
    );

    pipe_payload_reg #(.W(PW), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_skid_en),
        .i_clr_ctrl (flush),
        .i_d        (w_in_bus),
        .o_q        (w_skid_q)
    );

    // Side-effecting controls are masked to a bubble when nothing is valid.
    assign RegWriteE = w_main_q[PW-1] & r_out_valid;
    assign MemtoRegE = w_main_q[PW-2] & r_out_valid;
    assign MemWriteE = w_main_q[PW-3] & r_out_valid;
    assign BranchE   = w_main_q[PW-4] & r_out_valid;
    assign {ALUSrcE, ALUControlE, WA3E, rd1E, rd2E, ExtImmE} = w_main_q[PW-5:0];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occ       = r_state;

endmodule

// File: tb/tb_pipe_id_ex_skid.sv
// Directed bench for the ID/EX skid stage (default and 64-bit instances).
module tb_pipe_id_ex_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
    logic [2:0]  ALUControlD;
    logic [3:0]  WA3D;
    logic [31:0] rd1D, rd2D, ExtImmD;
    logic        in_ready, out_valid;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [3:0]  WA3E;
    logic [31:0] rd1E, rd2E, ExtImmE;
    logic [1:0]  occ;

    logic [3:0]  alu64_d;
    logic [4:0]  wa64_d;
    logic [63:0] rd1_64d, rd2_64d, imm64_d;
    logic        in_ready64, out_valid64;
    logic        rw64, m2r64, mw64, br64, as64;
    logic [3:0]  alu64_e;
    logic [4:0]  wa64_e;
    logic [63:0] rd1_64e, rd2_64e, imm64_e;
    logic [1:0]  occ64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_id_ex_skid u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .WA3D(WA3D),
        .rd1D(rd1D), .rd2D(rd2D), .ExtImmD(ExtImmD),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .WA3E(WA3E),
        .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE), .occ(occ)
    );

    pipe_id_ex_skid #(.DATA_W(64), .RA_W(5), .ALUC_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(alu64_d), .WA3D(wa64_d),
        .rd1D(rd1_64d), .rd2D(rd2_64d), .ExtImmD(imm64_d),
        .out_valid(out_valid64), .out_ready(out_ready),
        .RegWriteE(rw64), .MemtoRegE(m2r64), .MemWriteE(mw64),
        .BranchE(br64), .ALUSrcE(as64), .ALUControlE(alu64_e), .WA3E(wa64_e),
        .rd1E(rd1_64e), .rd2E(rd2_64e), .ExtImmE(imm64_e), .occ(occ64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge (outputs settled).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] d1, input logic rw, input logic mw);
        in_valid  = v;
        rd1D      = d1;
        RegWriteD = rw;
        MemWriteD = mw;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".occ"},  64'(occ), 64'd0);
        chk({tag, ".ov"},   64'(out_valid), 64'd0);
        chk({tag, ".ir"},   64'(in_ready), 64'd1);
        chk({tag, ".ctl"},  64'({RegWriteE, MemtoRegE, MemWriteE, BranchE}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; ALUSrcD = 0;
        ALUControlD = 3'd0; WA3D = 4'd0; rd1D = 0; rd2D = 0; ExtImmD = 0;
        alu64_d = 4'd0; wa64_d = 5'd0; rd1_64d = 0; rd2_64d = 0; imm64_d = 0;

        #3;
        chk_idle("rst");
        chk("rst.data", {rd1E, rd2E}, 64'd0);
        #10 rst = 1'b0;

        // Streaming with EX always ready: one-edge latency, occ stays at 1.
        step();
        out_ready = 1'b1;
        offer(1'b1, 32'h11, 1'b1, 1'b0);
        ALUControlD = 3'd5; WA3D = 4'd9; ExtImmD = 32'hCAFE_0001;
        rd1_64d = 64'hFFFF_FFFF_0000_0001; imm64_d = 64'h8000_0000_0000_0003;
        alu64_d = 4'd13; wa64_d = 5'd31;
        step();
        chk("strm.A.rd1", 64'(rd1E), 64'h11);
        chk("strm.A.occ", 64'(occ), 64'd1);
        chk("strm.A.rw",  64'(RegWriteE), 64'd1);
        chk("strm.A.alu", 64'(ALUControlE), 64'd5);
        chk("strm.A.wa",  64'(WA3E), 64'd9);
        chk("strm.A.imm", 64'(ExtImmE), 64'hCAFE_0001);
        chk("w64.rd1",    rd1_64e, 64'hFFFF_FFFF_0000_0001);
        chk("w64.imm",    imm64_e, 64'h8000_0000_0000_0003);
        chk("w64.alu_wa", 64'({alu64_e, wa64_e}), 64'({4'd13, 5'd31}));
        offer(1'b1, 32'h22, 1'b1, 1'b0);
        step();
        chk("strm.B.rd1", 64'(rd1E), 64'h22);
        chk("strm.B.occ", 64'(occ), 64'd1);
        offer(1'b1, 32'h33, 1'b1, 1'b0);
        step();
        chk("strm.C.rd1", 64'(rd1E), 64'h33);
        chk("strm.C.occ", 64'(occ), 64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk_idle("strm.drain");
        chk("strm.drain.rd1", 64'(rd1E), 64'h33);

        // Backpressure: fill to FULL, C held off, then ordered drain.
        out_ready = 1'b0;
        offer(1'b1, 32'hA1, 1'b0, 1'b0);
        step();
        chk("bp.A.occ", 64'(occ), 64'd1);
        chk("bp.A.ir",  64'(in_ready), 64'd1);
        offer(1'b1, 32'hB2, 1'b0, 1'b0);
        step();
        chk("bp.B.occ", 64'(occ), 64'd2);
        chk("bp.B.ir",  64'(in_ready), 64'd0);
        chk("bp.B.rd1", 64'(rd1E), 64'hA1);
        offer(1'b1, 32'hC3, 1'b0, 1'b0);
        step();
        chk("bp.hold.occ", 64'(occ), 64'd2);
        chk("bp.hold.rd1", 64'(rd1E), 64'hA1);
        out_ready = 1'b1;
        step();
        chk("bp.d1.rd1", 64'(rd1E), 64'hB2);
        chk("bp.d1.occ", 64'(occ), 64'd1);
        step();
        chk("bp.d2.rd1", 64'(rd1E), 64'hC3);
        chk("bp.d2.occ", 64'(occ), 64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("bp.d3.occ", 64'(occ), 64'd0);

        // Flush from FULL with a competing offer.
        out_ready = 1'b0;
        offer(1'b1, 32'h51, 1'b1, 1'b1);
        step();
        offer(1'b1, 32'h52, 1'b1, 1'b1);
        step();
        chk("fl.pre.occ", 64'(occ), 64'd2);
        chk("fl.pre.ctl", 64'({RegWriteE, MemWriteE}), 64'd3);
        flush = 1'b1;
        offer(1'b1, 32'h99, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        chk_idle("fl.post");
        chk("fl.post.rd1", 64'(rd1E), 64'h51);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl.after.ov", 64'(out_valid), 64'd0);
        end

        // Idle bubble for five cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle.ov",  64'(out_valid), 64'd0);
            chk("idle.ctl", 64'({RegWriteE, MemWriteE, BranchE}), 64'd0);
        end

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0;
        BranchD = 1'b1; MemtoRegD = 1'b1;
        offer(1'b1, 32'h61, 1'b1, 1'b1);
        step();
        offer(1'b1, 32'h62, 1'b1, 1'b1);
        step();
        chk("ar.pre.occ", 64'(occ), 64'd2);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        BranchD = 1'b0; MemtoRegD = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle("ar.in");
        chk("ar.in.data", {rd1E, ExtImmE}, 64'd0);
        chk("ar.in.misc", 64'({ALUSrcE, ALUControlE, WA3E}), 64'd0);
        chk("ar.in.w64",  rd1_64e, 64'd0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        offer(1'b1, 32'h77, 1'b1, 1'b0);
        step();
        chk("ar.post.rd1", 64'(rd1E), 64'h77);
        chk("ar.post.occ", 64'(occ), 64'd1);
        offer(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        chk("ar.post.end", 64'(occ), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_id_ex_skid.md
PIPE_ID_EX_SKID -- requirements
Module: pipe_id_ex_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of rd1/rd2/ExtImm payload.
REQ-002 Parameter RA_W, default 4, width of destination register address WA3.
REQ-003 Parameter ALUC_W, default 3, width of ALU control field.
REQ-004 clk  input  1  pipeline clock; all state updates on the falling edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream (ID) offers a payload.
REQ-008 in_ready  output  1  stage accepts the upstream payload this cycle.
REQ-009 RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  input  1 each  ID control bits.
REQ-010 ALUControlD  input  ALUC_W  ID ALU control.
REQ-011 WA3D  input  RA_W  ID destination register.
REQ-012 rd1D, rd2D, ExtImmD  input  DATA_W each  ID operands and extended immediate.
REQ-013 out_valid  output  1  stage presents a payload to EX.
REQ-014 out_ready  input  1  downstream (EX) consumes the payload this cycle.
REQ-015 RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, ALUControlE, WA3E, rd1E, rd2E, ExtImmE  output  widths as ID counterparts  EX-side payload.
REQ-016 occ  output  2  number of held entries (0, 1, 2).

Function
REQ-017 Stage SHALL be a 2-entry skid buffer: main register (drives outputs) plus skid register.
REQ-018 States SHALL be EMPTY (occ=0), ONE (main valid), FULL (main and skid valid).
REQ-019 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only (no combinational path from out_ready).
REQ-020 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-021 Accept = in_valid & in_ready; consume = out_valid & out_ready; evaluated at each falling edge.
REQ-022 EMPTY: accept -> ONE, main <= input; otherwise stay.
REQ-023 ONE: accept & consume -> ONE, main <= input; accept only -> FULL, skid <= input; consume only -> EMPTY; neither -> hold.
REQ-024 FULL: consume -> ONE, main <= skid; otherwise hold; no input accepted.
REQ-025 Latency SHALL be one falling edge from accept to out_valid when EMPTY or when ONE with simultaneous consume.
REQ-026 Payload order SHALL be strictly FIFO; no payload duplicated or dropped except by flush or rst.
REQ-027 flush SHALL take priority over accept and consume: next state EMPTY, input offered in the same cycle discarded.
REQ-028 While out_valid=0, RegWriteE, MemtoRegE, MemWriteE, BranchE SHALL be forced 0 (bubble); other outputs hold last main-register value.
REQ-029 Flush SHALL clear the control bits of both registers to 0; data fields MAY retain values.
REQ-030 occ SHALL equal the state encoding at all times.

Reset
REQ-031 rst SHALL immediately force EMPTY and clear every payload bit of both registers to 0, independent of clk.
REQ-032 During and after rst: out_valid=0, in_ready=1, occ=0, all E-side outputs 0.
REQ-033 rst asserted mid-transfer SHALL discard both entries; first accept after release behaves as from EMPTY.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and default width constants DATA_W, RA_W, ALUC_W.
REQ-035 Sub-module pipe_payload_reg (enable-loaded, async-clear register of the full payload bundle) SHALL be instantiated twice, main and skid.

Verification
REQ-036 rst pulse mid-stream -> out_valid=0, in_ready=1, occ=0, all outputs 0 within the reset assertion, no clk edge required.
REQ-037 out_ready=1, stream A,B,C on in_valid each cycle (rd1D=0x11,0x22,0x33) -> rd1E 0x11,0x22,0x33 on consecutive edges, occ stays 1.
REQ-038 out_ready=0, offer A then B -> occ 1 then 2, in_ready=0; C held off; out_ready=1 -> A then B then C delivered in order.
REQ-039 FULL with RegWriteD=1 payloads, flush=1 with in_valid=1 -> next edge occ=0, RegWriteE=0, MemWriteE=0, offered payload never appears.
REQ-040 EMPTY, in_valid=0 for 5 cycles -> out_valid=0, RegWriteE=MemWriteE=BranchE=0 throughout.
REQ-041 Parameter sweep DATA_W=64, RA_W=5, ALUC_W=4, rd1D=0xFFFF_FFFF_0000_0001 -> rd1E identical, no truncation.
